// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the producer-side hazard scoreboard: writer kinds,
// shadow-slot indices and the per-slot record.
package hazard_scoreboard_pkg;

  localparam int unsigned NUM_SLOTS  = 3;
  localparam int unsigned GPR_ADDR_W = 5;

  localparam int unsigned SLOT_EX     = 0;
  localparam int unsigned SLOT_DCACHE = 1;
  localparam int unsigned SLOT_MEM    = 2;

  typedef enum logic [1:0] {
    KIND_ALU    = 2'd0,
    KIND_LOAD   = 2'd1,
    KIND_MULDIV = 2'd2,
    KIND_RSVD   = 2'd3
  } kind_e;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [GPR_ADDR_W-1:0] waddr;
    kind_e                 kind;
    logic                  ready;
  } slot_t;

  // Reserved kind behaves like ALU: result forwardable from EX.
  function automatic logic ready_at_entry(input kind_e k);
    return (k != KIND_LOAD) && (k != KIND_MULDIV);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_slot_match.sv
// One source register checked against every shadow slot; the youngest
// matching writer decides whether the source must wait.
module hazard_slot_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NSTAGE     = 3,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  slot_t [NSTAGE-1:0]     slots,
  input  logic [REG_ADDR_W-1:0]  src,
  input  logic                   used,
  output logic                   hazard
);

  logic found;

  always_comb begin
    hazard = 1'b0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NSTAGE; i++) begin
      if (!found && used && (src != '0) && slots[i].valid && slots[i].we &&
          (slots[i].waddr == src)) begin
        found  = 1'b1;
        hazard = ~slots[i].ready;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Shadows in-flight GPR writers in EX/DCACHE/MEM and raises stallreq when
// the youngest writer of an ID source cannot forward yet.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NSTAGE     = NUM_SLOTS,
  parameter int unsigned REG_ADDR_W = GPR_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  hold,
  input  logic                  id_valid,
  input  logic                  id_we,
  input  logic [REG_ADDR_W-1:0] id_waddr,
  input  logic [1:0]            id_kind,
  input  logic [REG_ADDR_W-1:0] rs_raddr,
  input  logic                  rs_used,
  input  logic [REG_ADDR_W-1:0] rt_raddr,
  input  logic                  rt_used,
  input  logic                  md_done,
  output logic                  stallreq,
  output logic                  stall_rs,
  output logic                  stall_rt
);

  slot_t [NSTAGE-1:0] slots;
  slot_t [NSTAGE-1:0] shifted;
  slot_t [NSTAGE-1:0] slots_next;
  slot_t              entry;
  logic               md_hit;

  hazard_slot_match #(.NSTAGE(NSTAGE), .REG_ADDR_W(REG_ADDR_W)) u_match_rs (
    .slots  (slots),
    .src    (rs_raddr),
    .used   (rs_used),
    .hazard (stall_rs)
  );

  hazard_slot_match #(.NSTAGE(NSTAGE), .REG_ADDR_W(REG_ADDR_W)) u_match_rt (
    .slots  (slots),
    .src    (rt_raddr),
    .used   (rt_used),
    .hazard (stall_rt)
  );

  assign stallreq = id_valid & (stall_rs | stall_rt);

  always_comb begin
    entry = '0;
    if (id_valid && !stallreq) begin
      entry.valid = 1'b1;
      entry.we    = id_we;
      entry.waddr = id_waddr;
      entry.kind  = kind_e'(id_kind);
      entry.ready = ready_at_entry(kind_e'(id_kind));
    end
  end

  // Shift (or freeze) first, then let md_done mark the oldest unready
  // MULDIV in the post-shift view; flush overrides everything.
  always_comb begin
    shifted = slots;
    if (!hold) begin
      shifted[SLOT_EX] = entry;
      for (int unsigned i = SLOT_DCACHE; i < NSTAGE; i++) begin
        shifted[i] = slots[i-1];
      end
      if (shifted[SLOT_MEM].valid && (shifted[SLOT_MEM].kind == KIND_LOAD)) begin
        shifted[SLOT_MEM].ready = 1'b1;
      end
    end

    slots_next = shifted;
    md_hit     = 1'b0;
    for (int unsigned j = 0; j < NSTAGE; j++) begin
      if (md_done && !md_hit && shifted[NSTAGE-1-j].valid &&
          (shifted[NSTAGE-1-j].kind == KIND_MULDIV) && !shifted[NSTAGE-1-j].ready) begin
        slots_next[NSTAGE-1-j].ready = 1'b1;
        md_hit                       = 1'b1;
      end
    end

    if (flush) begin
      slots_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots <= '0;
    end else begin
      slots <= slots_next;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized checks of hazard_scoreboard against a queue-based
// model of the in-flight writers (youngest at the front).
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst, flush, hold, id_valid, id_we, rs_used, rt_used, md_done;
  logic [4:0] id_waddr, rs_raddr, rt_raddr;
  logic [1:0] id_kind;
  logic       stallreq, stall_rs, stall_rt;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    bit       valid;
    bit       we;
    bit [4:0] waddr;
    bit [1:0] kind;
    bit       ready;
  } ent_t;

  ent_t pipe[$];

  always #5 clk = ~clk;

  hazard_scoreboard #(.NSTAGE(3), .REG_ADDR_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .hold     (hold),
    .id_valid (id_valid),
    .id_we    (id_we),
    .id_waddr (id_waddr),
    .id_kind  (id_kind),
    .rs_raddr (rs_raddr),
    .rs_used  (rs_used),
    .rt_raddr (rt_raddr),
    .rt_used  (rt_used),
    .md_done  (md_done),
    .stallreq (stallreq),
    .stall_rs (stall_rs),
    .stall_rt (stall_rt)
  );

  function automatic void m_clear();
    pipe.delete();
    repeat (3) pipe.push_back('0);
  endfunction

  function automatic bit m_hz(bit [4:0] src, bit used);
    if (!used || src == 0) return 1'b0;
    foreach (pipe[i])
      if (pipe[i].valid && pipe[i].we && pipe[i].waddr == src) return !pipe[i].ready;
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    return id_valid && (m_hz(rs_raddr, rs_used) || m_hz(rt_raddr, rt_used));
  endfunction

  function automatic void m_update(bit st);
    ent_t e;
    if (flush) begin
      m_clear();
      return;
    end
    if (!hold) begin
      e = '0;
      if (id_valid && !st) begin
        e.valid = 1'b1;
        e.we    = id_we;
        e.waddr = id_waddr;
        e.kind  = id_kind;
        e.ready = (id_kind == 2'd0) || (id_kind == 2'd3);
      end
      pipe.push_front(e);
      void'(pipe.pop_back());
      if (pipe[2].valid && pipe[2].kind == 2'd1) begin
        e = pipe[2];
        e.ready = 1'b1;
        pipe[2] = e;
      end
    end
    if (md_done) begin
      for (int i = 2; i >= 0; i--) begin
        if (pipe[i].valid && pipe[i].kind == 2'd2 && !pipe[i].ready) begin
          e = pipe[i];
          e.ready = 1'b1;
          pipe[i] = e;
          break;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic cm(input string tag);
    chk({tag, ".stallreq"}, stallreq, m_stall());
    chk({tag, ".stall_rs"}, stall_rs, m_hz(rs_raddr, rs_used));
    chk({tag, ".stall_rt"}, stall_rt, m_hz(rt_raddr, rt_used));
  endtask

  task automatic drive(input bit v, input bit we, input logic [4:0] wa, input logic [1:0] k,
                       input logic [4:0] rs, input bit rsu, input logic [4:0] rt, input bit rtu,
                       input bit md = 1'b0, input bit fl = 1'b0, input bit hd = 1'b0);
    id_valid = v;  id_we = we;  id_waddr = wa;  id_kind = k;
    rs_raddr = rs; rs_used = rsu; rt_raddr = rt; rt_used = rtu;
    md_done = md;  flush = fl;  hold = hd;
    #1;
  endtask

  task automatic tick();
    bit st;
    st = m_stall();
    @(posedge clk);
    if (rst) m_clear();
    else m_update(st);
    #2;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    m_clear();
    rst = 1'b1;
    drive(1, 1, 1, 0, 1, 1, 1, 1);
    chk("reset.stallreq", stallreq, 1'b0);
    chk("reset.stall_rs", stall_rs, 1'b0);
    chk("reset.stall_rt", stall_rt, 1'b0);
    tick();
    rst = 1'b0;
    drain();

    // ALU producer forwards from EX: never stalls
    drive(1, 1, 5, 0, 0, 0, 0, 0); cm("alu_prod"); tick();
    drive(1, 0, 0, 0, 5, 1, 0, 0); chk("alu_fwd", stallreq, 1'b0); cm("alu_fwd"); tick();
    drain();

    // LOAD r8 -> rt reader stalls twice, released with load in MEM
    drive(1, 1, 8, 1, 0, 0, 0, 0); cm("ld_prod"); tick();
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 0, 0, 0, 8, 1);
      chk("ld_stall", stallreq, 1'b1);
      chk("ld_stall_rt", stall_rt, 1'b1);
      chk("ld_stall_rs", stall_rs, 1'b0);
      cm("ld_stall");
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 8, 1); chk("ld_release", stallreq, 1'b0); cm("ld_release"); tick();
    drain();

    // MULDIV r9: controller holds once it reaches MEM; md_done in 4th stall cycle
    drive(1, 1, 9, 2, 0, 0, 0, 0); cm("md_prod"); tick();
    for (int k = 1; k <= 4; k++) begin
      drive(1, 0, 0, 0, 9, 1, 0, 0, k == 4, 0, k >= 3);
      chk("md_stall", stallreq, 1'b1);
      cm("md_stall");
      tick();
    end
    drive(1, 0, 0, 0, 9, 1, 0, 0); chk("md_release", stallreq, 1'b0); cm("md_release"); tick();
    drain();

    // Youngest writer decides: ALU r3 in EX shadows LOAD r3 in DCACHE
    drive(1, 1, 3, 1, 0, 0, 0, 0); tick();
    drive(1, 1, 3, 0, 0, 0, 0, 0); cm("young_alu"); tick();
    drive(1, 0, 0, 0, 3, 1, 0, 0); chk("young_wins", stallreq, 1'b0); cm("young_wins"); tick();
    drain();

    // r0 never hazards
    drive(1, 1, 0, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 1, 0, 1); chk("r0_no_stall", stallreq, 1'b0); cm("r0"); tick();
    drain();

    // Flush clears an in-flight load
    drive(1, 1, 4, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
    drive(1, 0, 0, 0, 4, 1, 0, 0); chk("flush_clear", stallreq, 1'b0); cm("flush"); tick();
    drain();

    // Hold freezes the load in EX; stall persists until it reaches MEM
    drive(1, 1, 4, 1, 0, 0, 0, 0); tick();
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 0, 4, 1, 0, 0, 0, 0, 1); chk("hold_stall", stallreq, 1'b1); cm("hold"); tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 0, 4, 1, 0, 0); chk("post_hold_stall", stallreq, 1'b1); cm("post_hold"); tick();
    end
    drive(1, 0, 0, 0, 4, 1, 0, 0); chk("post_hold_release", stallreq, 1'b0); cm("post_hold_rel"); tick();
    drain();

    // Async reset mid-stall
    drive(1, 1, 4, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 4, 1, 0, 0); chk("pre_rst_stall", stallreq, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_async", stallreq, 1'b0);
    m_clear();
    tick();
    rst = 1'b0;
    drain();

    // Randomized traffic over a small register set to provoke hazards
    repeat (800) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 1), 5'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 1),
            5'($urandom_range(0, 3)), $urandom_range(0, 1),
            $urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 6) == 0);
      cm("rand");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
